seg_led_scan: RTL and testbench

- Producer side of the 7-segment path: accepts a binary value and converts it to BCD with a sequential double-dabble engine.
- Time-multiplexes the BCD digits onto one 4-bit digit code plus a one-hot digit select.
- data_disp feeds the board's hex-to-segment decoder directly. Codes 4'hA–4'hF decode to all segments off, so 4'hF is the blank code.

---
 rtl/seg_led_scan.sv | 172 +++++++++++++++++
 tb/tb_seg_led_scan.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_led_scan.sv
// Binary-to-BCD conversion with a sequential double-dabble engine, plus a time-multiplexed
// digit scanner. Leading-zero blanking is enabled with the SEG_LED_SCAN_BLANK_EN macro.

// Double-dabble nibble adjust: add 3 to a nibble that is 5 or more, before the shift.
module seg_led_scan_nib (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);
  assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;
endmodule

module seg_led_scan #(
  parameter int DATA_W   = 20,
  parameter int DIGITS   = 6,
  parameter int SCAN_DIV = 50000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [3:0]        data_disp,
  output logic [DIGITS-1:0] seg_sel,
  output logic              busy
);
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  // Saturation only applies when the input range can exceed the displayable range.
  localparam longint unsigned MAX_L = pow10(DIGITS) - 1;
  localparam bit SAT_EN = (DATA_W >= 64) || (((64'd1 << DATA_W) - 64'd1) > MAX_L);
  localparam logic [DATA_W-1:0] MAX_W = DATA_W'(MAX_L);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                   state_q, state_d;
  logic [DATA_W-1:0]        op_q, op_d;
  logic [DIGITS-1:0][3:0]   scr_q, scr_d, adj;
  logic [DIGITS-1:0][3:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     rdy_q, rdy_d;
  logic                     busy_q, busy_d;

  logic [SCAN_W-1:0]        scnt_q, scnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [DIGITS-1:0]        sel_q, sel_d;
  logic [3:0]               disp_q, disp_d;
  logic [DIGITS-1:0]        blank;
  logic                     tick;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_nib
      seg_led_scan_nib u_nib (.nib_i(scr_q[g]), .nib_o(adj[g]));
    end
  endgenerate

  // ---------------- converter ----------------
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    rdy_d   = rdy_q;
    case (state_q)
      IDLE: begin
        if (in_valid && rdy_q) begin
          op_d    = (SAT_EN && (in_data > MAX_W)) ? MAX_W : in_data;
          scr_d   = '0;
          cnt_d   = '0;
          rdy_d   = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {scr_d, op_d} = {adj, op_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
      end
      DONE: begin
        bcd_d   = scr_q;
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
    busy_d = ~rdy_d;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  // ---------------- blanking ----------------
  // Digit i blanks when it and every more-significant digit are zero; digit 0 never blanks.
`ifdef SEG_LED_SCAN_BLANK_EN
  logic lead;
  always_comb begin
    blank = '0;
    lead  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lead     = lead && (bcd_q[i] == 4'd0);
      blank[i] = lead;
    end
  end
`else
  assign blank = '0;
`endif

  // ---------------- scan ----------------
  // idx_q names the digit to show on the next tick, so the first tick after reset lights digit 0.
  assign tick = (scnt_q == SCAN_W'(SCAN_DIV - 1));

  always_comb begin
    scnt_d = tick ? '0 : scnt_q + 1'b1;
    idx_d  = idx_q;
    sel_d  = sel_q;
    disp_d = disp_q;
    if (tick) begin
      idx_d  = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      sel_d  = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_q);
      disp_d = blank[idx_q] ? 4'hF : bcd_q[idx_q];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scnt_q <= '0;
      idx_q  <= '0;
      sel_q  <= '1;
      disp_q <= 4'h0;
    end else begin
      scnt_q <= scnt_d;
      idx_q  <= idx_d;
      sel_q  <= sel_d;
      disp_q <= disp_d;
    end
  end

  assign in_ready  = rdy_q;
  assign busy      = busy_q;
  assign seg_sel   = sel_q;
  assign data_disp = disp_q;

endmodule

// File: tb/tb_seg_led_scan.sv
// Directed bench for seg_led_scan with SCAN_DIV=4: vector table of conversions plus
// hand-written reset, back-to-back and busy-input sequences.
module tb_seg_led_scan;
  localparam int DATA_W = 20, DIGITS = 6, SCAN_DIV = 4;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        data_disp;
  logic [DIGITS-1:0] seg_sel;
  logic              busy;

  seg_led_scan #(.DATA_W(DATA_W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .data_disp(data_disp), .seg_sel(seg_sel), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int dbad   = 0;

  typedef struct {
    logic [19:0] din;
    logic [23:0] nb;
    logic [23:0] bl;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pick(input logic [23:0] nb, input logic [23:0] bl);
`ifdef SEG_LED_SCAN_BLANK_EN
    return bl;
`else
    return nb;
`endif
  endfunction

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s ready-timeout actual=0 required=1", name);
    end
  endtask

  task automatic do_convert(input string name, input logic [19:0] v);
    int low = 0, bmis = 0;
    wait_ready(name);
    in_valid = 1'b1;
    in_data  = v;
    @(posedge sys_clk);
    @(negedge sys_clk);
    in_valid = 1'b0;
    while (!in_ready && low < 100) begin
      low++;
      if (busy !== 1'b1) bmis++;
      @(negedge sys_clk);
    end
    chk({name, " ready-low-cycles"}, low, 21);
    chk({name, " busy-tracks"}, bmis, 0);
  endtask

  // Let the scan refresh every slot, then record one full rotation.
  task automatic capture(input string name, input logic [23:0] exp);
    logic [23:0] w = 24'hAAAAAA;
    int bad = 0;
    bit found;
    repeat (2 * DIGITS * SCAN_DIV) @(negedge sys_clk);
    for (int c = 0; c < DIGITS * SCAN_DIV; c++) begin
      found = 1'b0;
      for (int d = 0; d < DIGITS; d++)
        if (seg_sel == ~(6'b1 << d)) begin
          w[d*4 +: 4] = data_disp;
          found = 1'b1;
        end
      if (!found) bad++;
      @(negedge sys_clk);
    end
    chk({name, " digits"}, {8'h0, w}, {8'h0, exp});
    chk({name, " onehot"}, bad, 0);
  endtask

  // Back-to-back values are 7 then 42 starting from 0; no other digit may appear.
  task automatic disp_ok();
    for (int d = 0; d < DIGITS; d++)
      if (seg_sel == ~(6'b1 << d)) begin
        if (d == 0) begin
          if (!(data_disp inside {4'd0, 4'd7, 4'd2})) dbad++;
        end else if (d == 1) begin
          if (!(data_disp == 4'd4 || data_disp == pick(24'h0, 24'hF)) ) dbad++;
        end else if (data_disp != pick(24'h0, 24'hF)) dbad++;
      end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    int n, low, prev_idx, cur_idx, last, gapbad, seqbad, changes, wraps, acc_low, acc_done;
    logic [DIGITS-1:0] prev;

    vt[0] = '{20'd12345,   24'h012345, 24'hF12345};
    vt[1] = '{20'hFFFFF,   24'h999999, 24'h999999};
    vt[2] = '{20'd907,     24'h000907, 24'hFFF907};
    vt[3] = '{20'd0,       24'h000000, 24'hFFFFF0};
    vt[4] = '{20'd999999,  24'h999999, 24'h999999};
    vt[5] = '{20'd1000000, 24'h999999, 24'h999999};
    vt[6] = '{20'd100000,  24'h100000, 24'h100000};
    vt[7] = '{20'd9,       24'h000009, 24'hFFFFF9};

    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("rst ready", in_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst seg_sel", seg_sel, 6'h3F);
    chk("rst disp", data_disp, 0);
    sys_rst_n = 1'b1;
    n = 0;
    while (seg_sel == 6'h3F && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    chk("first tick digit0", seg_sel, 6'h3E);
    chk("first tick delay", n, SCAN_DIV);

    // Reset eight cycles into a conversion
    wait_ready("midrst");
    in_valid = 1'b1;
    in_data  = 20'd12345;
    @(posedge sys_clk);
    @(negedge sys_clk);
    in_valid = 1'b0;
    repeat (7) @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("midrst ready", in_ready, 1);
    chk("midrst busy", busy, 0);
    chk("midrst seg_sel", seg_sel, 6'h3F);
    chk("midrst disp", data_disp, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    capture("midrst", pick(24'h000000, 24'hFFFFF0));
    chk("midrst idle", in_ready, 1);

    // Back-to-back: hold valid with 7, then 42
    dbad = 0;
    wait_ready("b2b");
    in_valid = 1'b1;
    in_data  = 20'd7;
    @(posedge sys_clk);
    @(negedge sys_clk);
    in_data = 20'd42;
    low = 0;
    while (!in_ready && low < 100) begin
      low++;
      disp_ok();
      @(negedge sys_clk);
    end
    chk("b2b first low", low, 21);
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("b2b 42 accepted", in_ready, 0);
    in_valid = 1'b0;
    low = 0;
    while (!in_ready && low < 100) begin
      low++;
      disp_ok();
      @(negedge sys_clk);
    end
    chk("b2b second low", low, 21);
    repeat (60) begin
      disp_ok();
      @(negedge sys_clk);
    end
    chk("b2b no stray digit", dbad, 0);
    capture("b2b", pick(24'h000042, 24'hFFFF42));

    // Table of conversions
    for (int i = 0; i < 8; i++) begin
      do_convert($sformatf("vec%0d", i), vt[i].din);
      capture($sformatf("vec%0d", i), pick(vt[i].nb, vt[i].bl));
    end

    // Input held during busy; scan order and spacing watched throughout
    wait_ready("busyin");
    in_valid = 1'b1;
    in_data  = 20'd100000;
    @(posedge sys_clk);
    @(negedge sys_clk);
    in_data  = 20'd999;
    acc_low  = 0;
    acc_done = 0;
    fork
      begin
        low = 1;
        while (!in_ready && low < 100) begin
          @(negedge sys_clk);
          if (!in_ready) low++;
        end
        chk("busyin ignored low", low, 21);
        @(posedge sys_clk);
        @(negedge sys_clk);
        acc_low  = in_ready ? 0 : 1;
        in_valid = 1'b0;
        acc_done = 1;
      end
      begin
        prev = seg_sel;
        last = -1;
        gapbad = 0; seqbad = 0; changes = 0; wraps = 0;
        for (int c = 1; c <= 60; c++) begin
          @(negedge sys_clk);
          if (seg_sel !== prev) begin
            prev_idx = -1;
            cur_idx  = -1;
            for (int d = 0; d < DIGITS; d++) begin
              if (prev == ~(6'b1 << d)) prev_idx = d;
              if (seg_sel == ~(6'b1 << d)) cur_idx = d;
            end
            if (prev_idx < 0 || cur_idx != (prev_idx + 1) % DIGITS) seqbad++;
            if (prev == 6'h1F && seg_sel == 6'h3E) wraps++;
            if (last >= 0 && c - last != SCAN_DIV) gapbad++;
            last = c;
            changes++;
            prev = seg_sel;
          end
        end
      end
    join
    chk("busyin 999 accepted", acc_low, 1);
    chk("busyin accept seen", acc_done, 1);
    chk("scan order", seqbad, 0);
    chk("scan spacing", gapbad, 0);
    chk("scan slots", changes, 15);
    chk("scan wrap", (wraps >= 2) ? 1 : 0, 1);
    wait_ready("busyin end");
    capture("busyin", pick(24'h000999, 24'hFFF999));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
